// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus decoder: FSM state encoding and the
// default read data returned on an error completion.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    HOLD
  } bus_state_e;

  localparam logic [15:0] BUS_ERR_DATA = 16'hdead;

endpackage

// File: rtl/bus_watchdog.sv
// Access timeout counter: cleared outside ACCESS, counts each ACCESS cycle and
// flags expiry on the TIMEOUT-th cycle without a slave ready.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is flagged during the last allowed cycle so the strobe is high
  // for exactly TIMEOUT cycles.
  assign expired_o = start_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (start_i && !expired_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_decoder.sv
// CPU-to-slave bus interconnect: base/mask decode, single-slave handshake and
// error completion. Define BUS_DECODER_TIMEOUT_EN to enable the access watchdog.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int unsigned       AW       = 16,
  parameter int unsigned       DW       = 16,
  parameter int unsigned       N        = 4,
  // Slot i occupies bits [i*AW +: AW]; slots 0/1 are GPIO, 2 is RAM, 3 is ROM.
  parameter logic [N*AW-1:0]   BASE     = {16'h0000, 16'h8000, 16'hffff, 16'hfffe},
  parameter logic [N*AW-1:0]   MASK     = {16'h8000, 16'h8000, 16'hffff, 16'hffff},
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DW-1:0]     ERR_DATA = DW'(BUS_ERR_DATA)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [AW-1:0]     address,
  input  logic [DW-1:0]     data_out,
  output logic [DW-1:0]     data_in,
  output logic              ready,
  output logic [N-1:0]      s_read,
  output logic [N-1:0]      s_write,
  output logic [AW-1:0]     s_address,
  output logic [DW-1:0]     s_wdata,
  input  logic [N-1:0]      s_ready,
  input  logic [N*DW-1:0]   s_rdata,
  output logic              bus_error,
  output logic [AW-1:0]     err_address
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("bus_decoder: TIMEOUT must be >= 1");
  end

  bus_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, erraddr_q;
  logic [DW-1:0] wdata_q, rdata_q, sel_rdata;
  logic [N-1:0]  sel_q, match_oh;
  logic          is_rd_q, err_q;
  logic          hit, req, conflict, sel_ready, timeout_hit;

  assign req       = read | write;
  assign conflict  = read & write;
  assign sel_ready = |(s_ready & sel_q);

  // Lowest matching slot wins when the map overlaps.
  always_comb begin
    match_oh = '0;
    hit      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit && ((address & MASK[i*AW +: AW]) == BASE[i*AW +: AW])) begin
        match_oh[i] = 1'b1;
        hit         = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < N; i++)
      if (sel_q[i]) sel_rdata = sel_rdata | s_rdata[i*DW +: DW];
  end

`ifdef BUS_DECODER_TIMEOUT_EN
  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_i     (reset),
    .start_i   (state_q == ACCESS),
    .clear_i   (state_q != ACCESS),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (conflict || !hit) ? RESP : ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == RESP);
    bus_error = (state_q == RESP) && err_q;
    s_read    = '0;
    s_write   = '0;
    if (state_q == ACCESS) begin
      if (is_rd_q) s_read  = sel_q;
      else         s_write = sel_q;
    end
  end

  // Response data and error address are loaded on the edge entering RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      erraddr_q <= '0;
      sel_q     <= '0;
      is_rd_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= address;
            wdata_q <= data_out;
            is_rd_q <= read;
            sel_q   <= conflict ? '0 : match_oh;
            err_q   <= conflict || !hit;
            if (conflict || !hit) begin
              erraddr_q <= address;
              if (read) rdata_q <= ERR_DATA;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            if (is_rd_q) rdata_q <= sel_rdata;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            erraddr_q <= addr_q;
            if (is_rd_q) rdata_q <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_in     = rdata_q;
  assign s_address   = addr_q;
  assign s_wdata     = wdata_q;
  assign err_address = erraddr_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: default 4-slot map plus a 2-slot map
// with an unmapped hole; timeout behaviour follows BUS_DECODER_TIMEOUT_EN.
module tb_bus_decoder;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic [15:0] eaddr;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-slot instance (default map)
  logic        rd, wr, rdy, berr;
  logic [15:0] addr, wdat, din, saddr, swdat, eaddr;
  logic [3:0]  srd, swr, srdy;
  logic [63:0] srdata;

  // 2-slot instance with an unmapped region
  logic        rd2, wr2, rdy2, berr2;
  logic [15:0] addr2, wdat2, din2, saddr2, swdat2, eaddr2;
  logic [1:0]  srd2, swr2, srdy2;
  logic [31:0] srdata2;

  bus_decoder #(
    .AW (16), .DW (16), .N (4), .TIMEOUT (4)
  ) u_dut (
    .clk (clk), .reset (reset), .read (rd), .write (wr), .address (addr),
    .data_out (wdat), .data_in (din), .ready (rdy), .s_read (srd),
    .s_write (swr), .s_address (saddr), .s_wdata (swdat), .s_ready (srdy),
    .s_rdata (srdata), .bus_error (berr), .err_address (eaddr)
  );

  bus_decoder #(
    .AW (16), .DW (16), .N (2), .TIMEOUT (4),
    .BASE ({16'h8000, 16'h0000}),
    .MASK ({16'hc000, 16'h8000})
  ) u_dut2 (
    .clk (clk), .reset (reset), .read (rd2), .write (wr2), .address (addr2),
    .data_out (wdat2), .data_in (din2), .ready (rdy2), .s_read (srd2),
    .s_write (swr2), .s_address (saddr2), .s_wdata (swdat2), .s_ready (srdy2),
    .s_rdata (srdata2), .bus_error (berr2), .err_address (eaddr2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    n_assert++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty at ready", name);
    end else begin
      e = sbq.pop_front();
      if (din !== e.data || berr !== e.err || eaddr !== e.eaddr) begin
        n_fail++;
        $display("FAIL %s got data_in=%h bus_error=%b err_address=%h want %h %b %h",
                 name, din, berr, eaddr, e.data, e.err, e.eaddr);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rd = 0; wr = 0; addr = '0; wdat = '0; srdy = '0; srdata = '0;
    rd2 = 0; wr2 = 0; addr2 = '0; wdat2 = '0; srdy2 = '0; srdata2 = '0;
    #3;
    n_assert++;
    if ({din, rdy, srd, swr, saddr, swdat, berr, eaddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got din=%h rdy=%b srd=%b swr=%b sa=%h sw=%h be=%b ea=%h want all zero",
               din, rdy, srd, swr, saddr, swdat, berr, eaddr);
    end
    step; step;
    reset = 1'b0;
    step;
    n_assert++;
    if (rdy !== 1'b0 || srd !== 4'b0 || swr !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got rdy=%b srd=%b swr=%b want 0 0 0", rdy, srd, swr);
    end
  endtask

  task automatic test_rom_read;
    sbq.push_back('{16'h1234, 1'b0, 16'h0000});
    rd = 1; addr = 16'h0005;
    step;
    n_assert++;
    if (srd !== 4'b1000 || rdy !== 1'b0 || saddr !== 16'h0005) begin
      n_fail++;
      $display("FAIL rom_strobe got srd=%b rdy=%b saddr=%h want 1000 0 0005", srd, rdy, saddr);
    end
    srdy = 4'b1000; srdata = '0; srdata[48 +: 16] = 16'h1234;
    step;
    n_assert++;
    if (rdy !== 1'b1 || srd !== 4'b0) begin
      n_fail++;
      $display("FAIL rom_ready_cycle2 got rdy=%b srd=%b want 1 0000", rdy, srd);
    end
    pop_check("rom_read_data");
    rd = 0; srdy = '0;
    step;
    n_assert++;
    if (rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rom_ready_pulse got rdy=%b want 0", rdy);
    end
    step;
  endtask

  task automatic test_gpio_write;
    sbq.push_back('{16'h1234, 1'b0, 16'h0000});
    wr = 1; addr = 16'hfffe; wdat = 16'h00a5;
    for (int c = 1; c <= 3; c++) begin
      step;
      n_assert++;
      if (swr !== 4'b0001 || srd !== 4'b0 || swdat !== 16'h00a5 || rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL gpio_write_cycle%0d got swr=%b srd=%b swdat=%h rdy=%b want 0001 0000 00a5 0",
                 c, swr, srd, swdat, rdy);
      end
      if (c == 3) srdy = 4'b0001;
    end
    step;
    n_assert++;
    if (rdy !== 1'b1 || swr !== 4'b0) begin
      n_fail++;
      $display("FAIL gpio_write_ready got rdy=%b swr=%b want 1 0000", rdy, swr);
    end
    pop_check("gpio_write_resp");
    srdy = '0;
    step;
    n_assert++;
    if (swr !== 4'b0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL gpio_hold_ignores got swr=%b rdy=%b want 0000 0", swr, rdy);
    end
    wr = 0;
    step;
    n_assert++;
    if (swr !== 4'b0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL gpio_after_hold got swr=%b rdy=%b want 0000 0", swr, rdy);
    end
  endtask

  task automatic test_miss;
    rd2 = 1; addr2 = 16'hc000;
    step;
    n_assert++;
    if (rdy2 !== 1'b1 || srd2 !== 2'b0 || din2 !== 16'hdead || berr2 !== 1'b1 || eaddr2 !== 16'hc000) begin
      n_fail++;
      $display("FAIL miss_resp got rdy=%b srd=%b din=%h be=%b ea=%h want 1 00 dead 1 c000",
               rdy2, srd2, din2, berr2, eaddr2);
    end
    rd2 = 0;
    step;
    n_assert++;
    if (rdy2 !== 1'b0 || berr2 !== 1'b0 || eaddr2 !== 16'hc000) begin
      n_fail++;
      $display("FAIL miss_pulse got rdy=%b be=%b ea=%h want 0 0 c000", rdy2, berr2, eaddr2);
    end
    step;
    rd2 = 1; addr2 = 16'h4000;
    step;
    n_assert++;
    if (srd2 !== 2'b01 || rdy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL map2_rom_hit got srd=%b rdy=%b want 01 0", srd2, rdy2);
    end
    srdy2 = 2'b01; srdata2 = 32'h0000_7777;
    step;
    n_assert++;
    if (rdy2 !== 1'b1 || berr2 !== 1'b0 || din2 !== 16'h7777 || eaddr2 !== 16'hc000) begin
      n_fail++;
      $display("FAIL map2_rom_read got rdy=%b be=%b din=%h ea=%h want 1 0 7777 c000",
               rdy2, berr2, din2, eaddr2);
    end
    rd2 = 0; srdy2 = '0;
    step; step;
  endtask

  task automatic test_conflict;
    rd = 1; wr = 1; addr = 16'h8000;
    step;
    n_assert++;
    if (srd !== 4'b0 || swr !== 4'b0 || rdy !== 1'b1 || berr !== 1'b1 || eaddr !== 16'h8000) begin
      n_fail++;
      $display("FAIL conflict got srd=%b swr=%b rdy=%b be=%b ea=%h want 0000 0000 1 1 8000",
               srd, swr, rdy, berr, eaddr);
    end
    rd = 0; wr = 0;
    step; step;
  endtask

  task automatic test_timeout;
    int hi;
    int pulses;
    bit got;
    rd = 1; addr = 16'h0005; srdy = '0;
`ifdef BUS_DECODER_TIMEOUT_EN
    sbq.push_back('{16'hdead, 1'b1, 16'h0005});
    hi = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step;
      if (srd == 4'b1000) hi++;
      if (rdy === 1'b1) got = 1;
    end
    n_assert++;
    if (!got || hi != 4) begin
      n_fail++;
      $display("FAIL timeout_strobe got ready_seen=%0d strobe_cycles=%0d want 1 4", got, hi);
    end
    if (got) pop_check("timeout_resp");
    rd = 0;
    step; step;
`else
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      step;
      if (rdy !== 1'b0) pulses++;
    end
    n_assert++;
    if (pulses != 0 || srd !== 4'b1000) begin
      n_fail++;
      $display("FAIL no_timeout_wait got ready_pulses=%0d srd=%b want 0 1000", pulses, srd);
    end
    #2 reset = 1'b1;
    #1;
    n_assert++;
    if (srd !== 4'b0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL hung_recover got srd=%b rdy=%b want 0000 0", srd, rdy);
    end
    rd = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    step;
`endif
  endtask

  task automatic test_reset_mid_access;
    int pulses;
    rd = 1; addr = 16'h8000; srdy = '0;
    step;
    n_assert++;
    if (srd !== 4'b0100) begin
      n_fail++;
      $display("FAIL ram_strobe got srd=%b want 0100", srd);
    end
    step;
    #2 reset = 1'b1;
    #1;
    n_assert++;
    if (srd !== 4'b0 || rdy !== 1'b0 || din !== 16'h0 || eaddr !== 16'h0 || saddr !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset got srd=%b rdy=%b din=%h ea=%h sa=%h want 0000 0 0000 0000 0000",
               srd, rdy, din, eaddr, saddr);
    end
    rd = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step;
      if (rdy !== 1'b0 || srd !== 4'b0) pulses++;
    end
    n_assert++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL discarded_access got %0d active cycles want 0", pulses);
    end
    sbq.push_back('{16'hbeef, 1'b0, 16'h0000});
    rd = 1; addr = 16'h8004;
    step;
    srdy = srd; srdata = '0; srdata[32 +: 16] = 16'hbeef;
    step;
    n_assert++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL fresh_read_ready got rdy=%b want 1", rdy);
    end
    pop_check("fresh_read_data");
    rd = 0; srdy = '0;
    step; step;
  endtask

  task automatic test_back_to_back;
    int  gap;
    bit  got;
    sbq.push_back('{16'h5a5a, 1'b0, 16'h0000});
    sbq.push_back('{16'h0f0f, 1'b0, 16'h0000});
    rd = 1; addr = 16'hffff;
    step;
    n_assert++;
    if (srd !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_first_strobe got srd=%b want 0010", srd);
    end
    srdy = 4'b0010; srdata = '0; srdata[16 +: 16] = 16'h5a5a;
    step;
    pop_check("b2b_first_data");
    addr = 16'h1000; srdy = '0;
    gap = 0; got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      step;
      gap++;
      if (srd !== 4'b0) got = 1;
    end
    n_assert++;
    if (!got || gap != 3 || srd !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_gap got strobe_seen=%0d gap=%0d srd=%b want 1 3 1000", got, gap, srd);
    end
    srdy = 4'b1000; srdata[48 +: 16] = 16'h0f0f;
    step;
    n_assert++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_ready got rdy=%b want 1", rdy);
    end
    pop_check("b2b_second_data");
    rd = 0; srdy = '0;
    step; step;
    n_assert++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sbq.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_rom_read();
    test_gpio_write();
    test_miss();
    test_conflict();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
